data_mem: RTL and testbench

DATA_MEM -- requirements
Module: data_mem

---
 rtl/data_mem_pkg.sv | 62 ++++++
 rtl/data_mem_byte_lane_ram.sv | 35 +++
 rtl/data_mem.sv | 112 +++++++++++
 tb/tb_data_mem.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared encodings, widths and lane helpers for the data memory block.
// Request sizes and response codes are fixed 2-bit encodings seen by the core.
package data_mem_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int MEM_COUNT_W = 2;
  localparam int MEM_CODE_W  = 2;
  localparam int NUM_LANES   = 4;
  localparam int LANE_W      = 8;

  typedef enum logic [MEM_COUNT_W-1:0] {
    MEM_COUNT_NONE = 2'd0,
    MEM_COUNT_BYTE = 2'd1,
    MEM_COUNT_HALF = 2'd2,
    MEM_COUNT_WORD = 2'd3
  } mem_count_e;

  typedef enum logic [MEM_CODE_W-1:0] {
    MEM_CODE_IDLE     = 2'd0,
    MEM_CODE_OK       = 2'd1,
    MEM_CODE_MISALIGN = 2'd2,
    MEM_CODE_RANGE    = 2'd3
  } mem_code_e;

  function automatic logic is_misaligned(input mem_count_e size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (size)
      MEM_COUNT_HALF: bad = lo[0];
      MEM_COUNT_WORD: bad = (lo != 2'b00);
      default:        bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Little-endian: lane 0 holds the lowest byte address.
  function automatic logic [NUM_LANES-1:0] lane_enables(input mem_count_e size,
                                                        input logic [1:0] lo);
    logic [NUM_LANES-1:0] en;
    en = '0;
    case (size)
      MEM_COUNT_BYTE: en[lo] = 1'b1;
      MEM_COUNT_HALF: en = lo[1] ? 4'b1100 : 4'b0011;
      MEM_COUNT_WORD: en = 4'b1111;
      default:        en = '0;
    endcase
    return en;
  endfunction

  function automatic logic [WORD_W-1:0] replicate_store(input mem_count_e size,
                                                        input logic [WORD_W-1:0] data);
    logic [WORD_W-1:0] rep;
    case (size)
      MEM_COUNT_BYTE: rep = {4{data[7:0]}};
      MEM_COUNT_HALF: rep = {2{data[15:0]}};
      default:        rep = data;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/data_mem_byte_lane_ram.sv
// Four independent byte lanes, synchronous write with per-lane enable and
// registered read. Contents are never reset.
module byte_lane_ram
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic [IDX_W-1:0]     addr_i,
  input  logic [NUM_LANES-1:0] we_i,
  input  logic [WORD_W-1:0]    wdata_i,
  input  logic                 re_i,
  output logic [WORD_W-1:0]    rdata_o
);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [LANE_W-1:0] mem [DEPTH];
    logic [LANE_W-1:0] rd_q;

    // A read and write on the same edge returns the old byte; the controller
    // never issues both in one cycle.
    always_ff @(posedge clk) begin
      if (we_i[g]) begin
        mem[addr_i] <= wdata_i[g*LANE_W +: LANE_W];
      end
      if (re_i) begin
        rd_q <= mem[addr_i];
      end
    end

    assign rdata_o[g*LANE_W +: LANE_W] = rd_q;
  end

endmodule

// File: rtl/data_mem.sv
// Byte-addressable data memory: request decode, alignment/range checks,
// store lane steering and a one-cycle registered response.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic [ADDR_W-1:0]      i_mem_req_addr,
  input  logic [WORD_W-1:0]      i_mem_req_wr_data,
  input  logic                   i_mem_req_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_mem_req_count,
  output logic [WORD_W-1:0]      o_mem_res_rd_data,
  output logic [MEM_CODE_W-1:0]  o_mem_res_code
);

  localparam int unsigned       IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] SPAN_BYTES = ADDR_W'(DEPTH_WORDS * 4);

  mem_count_e           req_size;
  logic [1:0]           req_lo;
  logic [ADDR_W-1:0]    req_offset;
  logic                 req_in_range;
  logic [IDX_W-1:0]     word_idx;
  mem_code_e            code_d;
  logic                 access_ok;
  logic                 store_en;
  logic                 load_en;
  logic [NUM_LANES-1:0] lane_we;
  logic [WORD_W-1:0]    lane_wdata;
  logic [WORD_W-1:0]    ram_rdata;

  mem_code_e            code_q;
  logic                 load_q;
  mem_count_e           size_q;
  logic [1:0]           lo_q;

  function automatic logic [WORD_W-1:0] align_load(input logic [WORD_W-1:0] word,
                                                   input mem_count_e size,
                                                   input logic [1:0] lo);
    logic [WORD_W-1:0] shifted;
    logic [WORD_W-1:0] res;
    shifted = word >> {lo, 3'b000};
    case (size)
      MEM_COUNT_BYTE: res = {24'b0, shifted[7:0]};
      MEM_COUNT_HALF: res = {16'b0, shifted[15:0]};
      MEM_COUNT_WORD: res = word;
      default:        res = '0;
    endcase
    return res;
  endfunction

  // Request decode. Below BASE_ADDR the subtraction would wrap, so the lower
  // bound is checked on the raw address before the offset is trusted.
  assign req_size     = mem_count_e'(i_mem_req_count);
  assign req_lo       = i_mem_req_addr[1:0];
  assign req_offset   = i_mem_req_addr - BASE_ADDR;
  assign req_in_range = (i_mem_req_addr >= BASE_ADDR) && (req_offset < SPAN_BYTES);
  assign word_idx     = req_offset[IDX_W+1:2];

  always_comb begin
    code_d = MEM_CODE_IDLE;
    if (req_size != MEM_COUNT_NONE) begin
      if (is_misaligned(req_size, req_lo)) begin
        code_d = MEM_CODE_MISALIGN;
      end else if (!req_in_range) begin
        code_d = MEM_CODE_RANGE;
      end else begin
        code_d = MEM_CODE_OK;
      end
    end
  end

  assign access_ok  = (code_d == MEM_CODE_OK);
  assign store_en   = access_ok && i_mem_req_wr_en && aresetn;
  assign load_en    = access_ok && !i_mem_req_wr_en;
  assign lane_we    = store_en ? lane_enables(req_size, req_lo) : '0;
  assign lane_wdata = replicate_store(req_size, i_mem_req_wr_data);

  byte_lane_ram #(
    .DEPTH (DEPTH_WORDS),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (clk),
    .addr_i  (word_idx),
    .we_i    (lane_we),
    .wdata_i (lane_wdata),
    .re_i    (load_en),
    .rdata_o (ram_rdata)
  );

  // ---- response register stage ----
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      code_q <= MEM_CODE_IDLE;
      load_q <= 1'b0;
      size_q <= MEM_COUNT_NONE;
      lo_q   <= 2'b00;
    end else begin
      code_q <= code_d;
      load_q <= load_en;
      size_q <= req_size;
      lo_q   <= req_lo;
    end
  end

  assign o_mem_res_code    = code_q;
  assign o_mem_res_rd_data = load_q ? align_load(ram_rdata, size_q, lo_q) : '0;

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: stores/loads, lane steering, error codes,
// and asynchronous reset behaviour with hand-computed expectations.
module tb_data_mem;
  import data_mem_pkg::*;

  logic        clk;
  logic        aresetn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr_en;
  logic [1:0]  count;
  logic [31:0] rd_data;
  logic [1:0]  code;

  int n_checks;
  int n_errors;

  localparam logic [1:0] C_NONE = 2'd0, C_BYTE = 2'd1, C_HALF = 2'd2, C_WORD = 2'd3;
  localparam logic [1:0] R_IDLE = 2'd0, R_OK = 2'd1, R_MIS = 2'd2, R_RANGE = 2'd3;

  data_mem #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0)
  ) dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .i_mem_req_addr    (addr),
    .i_mem_req_wr_data (wdata),
    .i_mem_req_wr_en   (wr_en),
    .i_mem_req_count   (count),
    .o_mem_res_rd_data (rd_data),
    .o_mem_res_code    (code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one request, clock it in, then check the response just after the edge.
  task automatic req(input string tag, input logic [1:0] cnt, input logic wr,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] exp_code, input logic [31:0] exp_data);
    count = cnt;
    wr_en = wr;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    check({tag, "_code"}, {30'b0, code}, {30'b0, exp_code});
    check({tag, "_data"}, rd_data, exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    aresetn  = 1'b0;
    count    = C_NONE;
    wr_en    = 1'b0;
    addr     = '0;
    wdata    = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_code", {30'b0, code}, 32'd0);
    check("reset_data", rd_data, 32'd0);
    @(negedge clk);
    aresetn = 1'b1;

    req("idle0",       C_NONE, 1'b0, 32'h0,    32'h0,        R_IDLE,  32'h0);
    req("st_word10",   C_WORD, 1'b1, 32'h10,   32'hDEADBEEF, R_OK,    32'h0);
    req("ld_word10",   C_WORD, 1'b0, 32'h10,   32'h0,        R_OK,    32'hDEADBEEF);
    req("st_byte12",   C_BYTE, 1'b1, 32'h12,   32'hFFFFFF55, R_OK,    32'h0);
    req("ld_word10b",  C_WORD, 1'b0, 32'h10,   32'h0,        R_OK,    32'hDE55BEEF);
    req("ld_half12",   C_HALF, 1'b0, 32'h12,   32'h0,        R_OK,    32'h0000DE55);
    req("ld_half11",   C_HALF, 1'b0, 32'h11,   32'h0,        R_MIS,   32'h0);
    req("st_word11",   C_WORD, 1'b1, 32'h11,   32'h12345678, R_MIS,   32'h0);
    req("ld_word10c",  C_WORD, 1'b0, 32'h10,   32'h0,        R_OK,    32'hDE55BEEF);
    req("ld_byte13",   C_BYTE, 1'b0, 32'h13,   32'h0,        R_OK,    32'h000000DE);
    req("ld_byte10",   C_BYTE, 1'b0, 32'h10,   32'h0,        R_OK,    32'h000000EF);
    req("ld_half10",   C_HALF, 1'b0, 32'h10,   32'h0,        R_OK,    32'h0000BEEF);

    req("ld_range",    C_WORD, 1'b0, 32'h1000, 32'h0,        R_RANGE, 32'h0);
    req("ld_rng_byte", C_BYTE, 1'b0, 32'h1003, 32'h0,        R_RANGE, 32'h0);
    req("ld_rng_mis",  C_WORD, 1'b0, 32'h1002, 32'h0,        R_MIS,   32'h0);
    req("st_word0",    C_WORD, 1'b1, 32'h0,    32'hA5A5A5A5, R_OK,    32'h0);
    req("st_range",    C_WORD, 1'b1, 32'h1000, 32'h11111111, R_RANGE, 32'h0);
    req("ld_word0",    C_WORD, 1'b0, 32'h0,    32'h0,        R_OK,    32'hA5A5A5A5);

    req("st_word20",   C_WORD, 1'b1, 32'h20,   32'h0,        R_OK,    32'h0);
    req("st_half22",   C_HALF, 1'b1, 32'h22,   32'h7777CAFE, R_OK,    32'h0);
    req("ld_word20",   C_WORD, 1'b0, 32'h20,   32'h0,        R_OK,    32'hCAFE0000);

    req("st_word30",   C_WORD, 1'b1, 32'h30,   32'h01020304, R_OK,    32'h0);
    req("gap_idle",    C_NONE, 1'b0, 32'h30,   32'h0,        R_IDLE,  32'h0);
    req("ld_word30",   C_WORD, 1'b0, 32'h30,   32'h0,        R_OK,    32'h01020304);
    req("st_last",     C_WORD, 1'b1, 32'hFFC,  32'h89ABCDEF, R_OK,    32'h0);
    req("ld_last",     C_WORD, 1'b0, 32'hFFC,  32'h0,        R_OK,    32'h89ABCDEF);

    // Mid-load reset: the response must clear before the next edge.
    req("pre_rst_ld",  C_WORD, 1'b0, 32'h10,   32'h0,        R_OK,    32'hDE55BEEF);
    #2;
    aresetn = 1'b0;
    #1;
    check("rst_async_code", {30'b0, code}, 32'd0);
    check("rst_async_data", rd_data, 32'd0);

    count = C_WORD;
    wr_en = 1'b1;
    addr  = 32'h10;
    wdata = 32'hBAADF00D;
    @(posedge clk);
    #1;
    check("rst_hold_code", {30'b0, code}, 32'd0);

    count = C_WORD;
    wr_en = 1'b0;
    addr  = 32'h30;
    wdata = 32'h0;
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    check("rel_pre_code", {30'b0, code}, 32'd0);
    check("rel_pre_data", rd_data, 32'd0);
    @(posedge clk);
    #1;
    check("rel_first_code", {30'b0, code}, {30'b0, R_OK});
    check("rel_first_data", rd_data, 32'h01020304);
    req("ld_after_rst", C_WORD, 1'b0, 32'h10,  32'h0,        R_OK,    32'hDE55BEEF);
    req("idle_end",     C_NONE, 1'b0, 32'h0,   32'h0,        R_IDLE,  32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
